// File: rtl/flac_pkg.sv
// Shared FLAC decode constants: channel-assignment codes, block-size limit and
// the decorrelator state encoding.
package flac_pkg;

  localparam int MAX_BLOCK = 4608;

  localparam logic [3:0] CH_MONO       = 4'd0;
  localparam logic [3:0] CH_INDEP      = 4'd1;
  localparam logic [3:0] CH_LEFT_SIDE  = 4'd8;
  localparam logic [3:0] CH_SIDE_RIGHT = 4'd9;
  localparam logic [3:0] CH_MID_SIDE   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CH0  = 2'd1,
    S_CH1  = 2'd2
  } state_t;

  function automatic logic assign_ok(input logic [3:0] a);
    return (a == CH_MONO) || (a == CH_INDEP) || (a == CH_LEFT_SIDE) ||
           (a == CH_SIDE_RIGHT) || (a == CH_MID_SIDE);
  endfunction

endpackage

// File: rtl/channel_decorrelator_if.sv
// Control, sample and output bus of the channel decorrelator, plus the FSM state
// for debug observation.
interface channel_decorrelator_if;
  import flac_pkg::*;

  // Handshake: no backpressure anywhere. iStart and iSampleValid are one-cycle
  // strobes consumed in the cycle they are high (iStart only in S_IDLE, samples
  // only while busy); oValid qualifies oLeft/oRight for exactly that cycle.
  logic        iStart;
  logic [15:0] iBlockSize;
  logic [3:0]  iChannelAssign;
  logic        iSampleValid;
  logic [16:0] iSample;
  logic        oValid;
  logic [15:0] oLeft;
  logic [15:0] oRight;
  logic        oBlockDone;
  logic        oBusy;
  logic        oError;
  state_t      state;

  modport master (
    output iStart, iBlockSize, iChannelAssign, iSampleValid, iSample,
    input  oValid, oLeft, oRight, oBlockDone, oBusy, oError, state
  );

  modport slave (
    input  iStart, iBlockSize, iChannelAssign, iSampleValid, iSample,
    output oValid, oLeft, oRight, oBlockDone, oBusy, oError, state
  );

endinterface

// File: rtl/channel_buffer.sv
// Simple dual-port synchronous RAM holding one channel of a block; reads return
// data one cycle after the address is presented.
module channel_buffer #(
  parameter int DEPTH = 4608,
  parameter int WIDTH = 17,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             iClock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge iClock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/channel_decorrelator.sv
// FLAC inter-channel decorrelation: buffers channel 0 of a block, then combines
// each channel-1 sample with its buffered partner into a left/right pair.
module channel_decorrelator #(
  parameter int MAX_BLOCK = flac_pkg::MAX_BLOCK
) (
  input  logic                   iClock,
  input  logic                   iReset,
  channel_decorrelator_if.slave  bus
);
  import flac_pkg::*;

  localparam int AW = $clog2(MAX_BLOCK);

  state_t      state_q, state_d;
  logic [15:0] size_q;
  logic [15:0] cnt_q;
  logic [3:0]  chan_q;
  logic        err_q;

  logic accept, cfg_ok, take, last;

  assign accept = (state_q == S_IDLE) && bus.iStart;
  assign cfg_ok = (bus.iBlockSize != 16'd0) &&
                  (bus.iBlockSize <= 16'(MAX_BLOCK)) &&
                  assign_ok(bus.iChannelAssign);
  assign take   = (state_q != S_IDLE) && bus.iSampleValid;
  assign last   = (cnt_q == size_q - 16'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && cfg_ok)
                state_d = (bus.iChannelAssign == CH_MONO) ? S_CH1 : S_CH0;
      S_CH0:  if (take && last) state_d = S_CH1;
      S_CH1:  if (take && last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= S_IDLE;
      size_q  <= '0;
      cnt_q   <= '0;
      chan_q  <= CH_MONO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (cfg_ok) begin
          size_q <= bus.iBlockSize;
          chan_q <= bus.iChannelAssign;
          cnt_q  <= '0;
          err_q  <= 1'b0;
        end else begin
          err_q  <= 1'b1;
        end
      end else if (take) begin
        cnt_q <= last ? 16'd0 : cnt_q + 16'd1;
      end
    end
  end

  // Stage 1: channel-0 writes, channel-1 read address issue and sample capture.
  logic [16:0] rd_data;

  channel_buffer #(.DEPTH(MAX_BLOCK), .WIDTH(17)) u_buf (
    .iClock (iClock),
    .we     (take && (state_q == S_CH0)),
    .waddr  (cnt_q[AW-1:0]),
    .wdata  (bus.iSample),
    .raddr  (cnt_q[AW-1:0]),
    .rdata  (rd_data)
  );

  logic        s1_valid, s1_last;
  logic [16:0] s1_sample;
  logic [3:0]  s1_chan;

  // The assignment travels with the sample so a new block can be latched while
  // the previous block's final pairs are still in flight.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sample <= '0;
      s1_chan   <= CH_MONO;
    end else begin
      s1_valid  <= take && (state_q == S_CH1);
      s1_last   <= last;
      s1_sample <= bus.iSample;
      s1_chan   <= chan_q;
    end
  end

  // Stage 2: combine buffered c0 with current c1.
  logic signed [17:0] c0, c1, m, l_full, r_full;

  always_comb begin
    c0     = {rd_data[16], rd_data};
    c1     = {s1_sample[16], s1_sample};
    m      = (c0 <<< 1) | {17'd0, c1[0]};
    l_full = c1;
    r_full = c1;
    case (s1_chan)
      CH_INDEP:      begin l_full = c0;      r_full = c1;      end
      CH_LEFT_SIDE:  begin l_full = c0;      r_full = c0 - c1; end
      CH_SIDE_RIGHT: begin l_full = c0 + c1; r_full = c1;      end
      CH_MID_SIDE:   begin
        l_full = (m + c1) >>> 1;
        r_full = (m - c1) >>> 1;
      end
      default:       begin l_full = c1;      r_full = c1;      end
    endcase
  end

  logic unused_high_bits;
  assign unused_high_bits = ^{l_full[17:16], r_full[17:16]};

  logic        valid_q, done_q;
  logic [15:0] left_q, right_q;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      valid_q <= s1_valid;
      done_q  <= s1_valid && s1_last;
      if (s1_valid) begin
        left_q  <= l_full[15:0];
        right_q <= r_full[15:0];
      end
    end
  end

  assign bus.oValid     = valid_q;
  assign bus.oBlockDone = done_q;
  assign bus.oLeft      = left_q;
  assign bus.oRight     = right_q;
  assign bus.oBusy      = (state_q != S_IDLE);
  assign bus.oError     = err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_channel_decorrelator.sv
// Directed bench for channel_decorrelator: table of small blocks plus hand
// sequences for errors, busy-ignore, mid-block reset and a full-size mono block.
module tb_channel_decorrelator;
  import flac_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  channel_decorrelator_if bus();

  channel_decorrelator #(.MAX_BLOCK(MAX_BLOCK)) dut (
    .iClock (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: cycle %0d reached without finishing, required finish", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        done;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [15:0] last_l = '0;
  logic [15:0] last_r = '0;

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_output: none by cycle %0d, required L=%h R=%h at cycle %0d",
                 cyc, exp_q[0].l, exp_q[0].r, exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (bus.oValid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_output: L=%h R=%h at cycle %0d, required no output",
                   bus.oLeft, bus.oRight, cyc);
          last_l = bus.oLeft;
          last_r = bus.oRight;
        end else begin
          e = exp_q.pop_front();
          if (bus.oLeft !== e.l || bus.oRight !== e.r || bus.oBlockDone !== e.done || cyc != e.due) begin
            n_errors++;
            $display("FAIL pair: got L=%h R=%h done=%b cycle=%0d, required L=%h R=%h done=%b cycle=%0d",
                     bus.oLeft, bus.oRight, bus.oBlockDone, cyc, e.l, e.r, e.done, e.due);
          end
          last_l = e.l;
          last_r = e.r;
        end
      end else begin
        n_checks++;
        if (bus.oBlockDone !== 1'b0 || bus.oLeft !== last_l || bus.oRight !== last_r) begin
          n_errors++;
          $display("FAIL hold: got L=%h R=%h done=%b, required L=%h R=%h done=0",
                   bus.oLeft, bus.oRight, bus.oBlockDone, last_l, last_r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, expv);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    exp_q.delete();
    last_l = '0;
    last_r = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_start(input logic [3:0] a, input logic [15:0] n);
    bus.iStart         = 1'b1;
    bus.iChannelAssign = a;
    bus.iBlockSize     = n;
    tick();
    bus.iStart         = 1'b0;
  endtask

  task automatic strobe(input logic [16:0] s, input logic want,
                        input logic [15:0] l, input logic [15:0] r, input logic done);
    exp_t x;
    bus.iSampleValid = 1'b1;
    bus.iSample      = s;
    if (want) begin
      x.l = l; x.r = r; x.done = done; x.due = cyc + 2;
      exp_q.push_back(x);
    end
    tick();
    bus.iSampleValid = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]        chan;
    int                n;
    logic [0:3][16:0]  c0;
    logic [0:3][16:0]  c1;
    logic [0:3][15:0]  l;
    logic [0:3][15:0]  r;
  } vec_t;

  vec_t vt[7];

  task automatic run_body(input vec_t v);
    if (v.chan != CH_MONO)
      for (int i = 0; i < v.n; i++) strobe(v.c0[i], 1'b0, 16'd0, 16'd0, 1'b0);
    for (int i = 0; i < v.n; i++) strobe(v.c1[i], 1'b1, v.l[i], v.r[i], i == v.n - 1);
  endtask

  initial begin
    bus.iStart = 1'b0; bus.iBlockSize = '0; bus.iChannelAssign = '0;
    bus.iSampleValid = 1'b0; bus.iSample = '0;

    vt[0] = '{chan: CH_INDEP, n: 4,
              c0: {17'(1), 17'(2), 17'(3), 17'(4)},
              c1: {17'(-1), 17'(-2), 17'(-3), 17'(-4)},
              l:  {16'(1), 16'(2), 16'(3), 16'(4)},
              r:  {16'(-1), 16'(-2), 16'(-3), 16'(-4)}};
    vt[1] = '{chan: CH_MID_SIDE, n: 2,
              c0: {17'(0), 17'(-3), 17'(0), 17'(0)},
              c1: {17'(1), 17'(-2), 17'(0), 17'(0)},
              l:  {16'(1), 16'(-4), 16'(0), 16'(0)},
              r:  {16'(0), 16'(-2), 16'(0), 16'(0)}};
    vt[2] = '{chan: CH_LEFT_SIDE, n: 1,
              c0: {17'(32767), 17'(0), 17'(0), 17'(0)},
              c1: {17'(-1), 17'(0), 17'(0), 17'(0)},
              l:  {16'h7fff, 16'(0), 16'(0), 16'(0)},
              r:  {16'h8000, 16'(0), 16'(0), 16'(0)}};
    vt[3] = '{chan: CH_SIDE_RIGHT, n: 1,
              c0: {17'(5), 17'(0), 17'(0), 17'(0)},
              c1: {17'(7), 17'(0), 17'(0), 17'(0)},
              l:  {16'(12), 16'(0), 16'(0), 16'(0)},
              r:  {16'(7), 16'(0), 16'(0), 16'(0)}};
    vt[4] = '{chan: CH_MONO, n: 3,
              c0: {17'(0), 17'(0), 17'(0), 17'(0)},
              c1: {17'(100), 17'(-200), 17'(32767), 17'(0)},
              l:  {16'(100), 16'(-200), 16'h7fff, 16'(0)},
              r:  {16'(100), 16'(-200), 16'h7fff, 16'(0)}};
    vt[5] = '{chan: CH_LEFT_SIDE, n: 2,
              c0: {17'(-32768), 17'(10), 17'(0), 17'(0)},
              c1: {17'(65535), 17'(3), 17'(0), 17'(0)},
              l:  {16'h8000, 16'(10), 16'(0), 16'(0)},
              r:  {16'h8001, 16'(7), 16'(0), 16'(0)}};
    vt[6] = '{chan: CH_MID_SIDE, n: 2,
              c0: {17'(100), 17'(-1), 17'(0), 17'(0)},
              c1: {17'(-3), 17'(65535), 17'(0), 17'(0)},
              l:  {16'(99), 16'h7fff, 16'(0), 16'(0)},
              r:  {16'(102), 16'h8000, 16'(0), 16'(0)}};

    // Reset state
    do_reset();
    check("rst_oValid",     32'(bus.oValid),     32'd0);
    check("rst_oBlockDone", 32'(bus.oBlockDone), 32'd0);
    check("rst_oBusy",      32'(bus.oBusy),      32'd0);
    check("rst_oError",     32'(bus.oError),     32'd0);
    check("rst_oLeft",      32'(bus.oLeft),      32'd0);
    check("rst_oRight",     32'(bus.oRight),     32'd0);
    check("rst_state",      32'(bus.state),      32'(S_IDLE));

    // Strobes while idle are ignored
    strobe(17'(9), 1'b0, 16'd0, 16'd0, 1'b0);

    // Table: back-to-back strobes per block
    for (int k = 0; k < 7; k++) begin
      drive_start(vt[k].chan, 16'(vt[k].n));
      check("start_busy", 32'(bus.oBusy), 32'd1);
      run_body(vt[k]);
      drain(3);
      check("end_busy",  32'(bus.oBusy),  32'd0);
      check("end_error", 32'(bus.oError), 32'd0);
    end

    // Bad configurations
    drive_start(CH_INDEP, 16'd0);
    check("err_size0",      32'(bus.oError), 32'd1);
    check("err_size0_busy", 32'(bus.oBusy),  32'd0);
    strobe(17'(3), 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(17'(4), 1'b0, 16'd0, 16'd0, 1'b0);
    drive_start(4'd12, 16'd2);
    check("err_assign12",      32'(bus.oError), 32'd1);
    check("err_assign12_busy", 32'(bus.oBusy),  32'd0);
    drive_start(CH_INDEP, 16'(MAX_BLOCK + 1));
    check("err_oversize", 32'(bus.oError), 32'd1);
    drive_start(CH_INDEP, 16'(MAX_BLOCK));
    check("err_cleared", 32'(bus.oError), 32'd0);
    check("maxsize_busy", 32'(bus.oBusy), 32'd1);
    do_reset();
    drive_start(CH_MID_SIDE, 16'd2);
    check("after_rst_busy", 32'(bus.oBusy), 32'd1);
    run_body(vt[1]);
    drain(3);

    // iStart while busy is ignored, gaps between strobes allowed
    drive_start(CH_INDEP, 16'd2);
    strobe(17'(10), 1'b0, 16'd0, 16'd0, 1'b0);
    drive_start(4'd12, 16'd0);
    check("busy_ign_err",  32'(bus.oError), 32'd0);
    check("busy_ign_busy", 32'(bus.oBusy),  32'd1);
    drive_start(CH_MONO, 16'd5);
    check("busy_ign_state", 32'(bus.state), 32'(S_CH0));
    strobe(17'(20), 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(17'(1), 1'b1, 16'd10, 16'd1, 1'b0);
    tick();
    strobe(17'(2), 1'b1, 16'd20, 16'd2, 1'b1);
    drain(3);

    // Reset after 2 of 4 channel-1 samples: only the first pair survives
    drive_start(CH_INDEP, 16'd4);
    for (int i = 0; i < 4; i++) strobe(17'(50 + i), 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(17'(60), 1'b1, 16'd50, 16'd60, 1'b0);
    strobe(17'(61), 1'b0, 16'd0, 16'd0, 1'b0);
    do_reset();
    check("midrst_busy", 32'(bus.oBusy), 32'd0);
    strobe(17'(62), 1'b0, 16'd0, 16'd0, 1'b0);
    strobe(17'(63), 1'b0, 16'd0, 16'd0, 1'b0);
    drive_start(vt[0].chan, 16'(vt[0].n));
    run_body(vt[0]);
    drain(3);

    // Full-size mono block, next block started in the cycle after the last strobe
    drive_start(CH_MONO, 16'(MAX_BLOCK));
    for (int i = 0; i < MAX_BLOCK; i++) begin
      logic [15:0] s;
      s = 16'($urandom_range(0, 65535));
      strobe({s[15], s}, 1'b1, s, s, i == MAX_BLOCK - 1);
    end
    drive_start(vt[0].chan, 16'(vt[0].n));
    check("b2b_busy", 32'(bus.oBusy), 32'd1);
    run_body(vt[0]);
    drain(4);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/channel_decorrelator.md
CHANNEL_DECORRELATOR -- requirements
Module: channel_decorrelator

Interface
REQ-001 Parameter MAX_BLOCK, default 4608, maximum samples per channel per block.
REQ-002 iClock  in  1  system clock; all logic on rising edge.
REQ-003 iReset  in  1  synchronous, active-high reset.
REQ-004 iStart  in  1  one-cycle pulse; latches iBlockSize and iChannelAssign, begins a block.
REQ-005 iBlockSize  in  16  samples per channel, valid range 1..MAX_BLOCK.
REQ-006 iChannelAssign  in  4  FLAC channel assignment: 0 mono, 1 independent stereo, 8 left/side, 9 side/right, 10 mid/side.
REQ-007 iSampleValid  in  1  one-cycle strobe from the subframe decoder; iSample is valid this cycle.
REQ-008 iSample  in  17  signed residual-reconstructed sample; the side channel uses all 17 bits, other channels are sign-extended 16-bit.
REQ-009 oValid  out  1  oLeft and oRight hold one decorrelated sample pair.
REQ-010 oLeft, oRight  out  16 each  signed output samples.
REQ-011 oBlockDone  out  1  one-cycle pulse, coincident with the last oValid of a block.
REQ-012 oBusy  out  1  high in states S_CH0 and S_CH1.
REQ-013 oError  out  1  sticky until next accepted iStart or iReset; flags a bad block size or assignment.

Function
REQ-014 States: S_IDLE, S_CH0, S_CH1.
- S_IDLE --iStart--> S_CH0 (S_CH1 for mono).
- S_CH0 --N-th sample--> S_CH1.
- S_CH1 --N-th sample--> S_IDLE.
REQ-015 iStart SHALL be ignored while oBusy=1.
REQ-016 iStart with iBlockSize=0, iBlockSize>MAX_BLOCK, or an assignment in {2..7, 11..15}: set oError, stay in S_IDLE, no output.
REQ-017 S_CH0: each strobed sample is written to the channel buffer at index k (0..N-1); no output is produced.
REQ-018 S_CH1: the sample at index k is paired with buffer[k]; the pair is computed and emitted.
REQ-019 Latency: oValid is asserted exactly 2 cycles after the accepted iSampleValid.
REQ-020 Back-to-back strobes (one every cycle) SHALL be supported with no loss; output order equals input order.
REQ-021 iSampleValid in S_IDLE SHALL be ignored.
REQ-022 A strobe beyond the N-th sample of a channel is impossible by state: the N-th sample always causes the state transition.
REQ-023 Arithmetic, with c0 = buffered sample and c1 = current sample, using 18-bit signed intermediates:
- mono: L = R = c1.
- independent (1): L = c0, R = c1.
- left/side (8): L = c0, R = c0 - c1.
- side/right (9): L = c0 + c1, R = c1.
- mid/side (10): m = (c0 << 1) | (c1 & 1); L = (m + c1) >>> 1; R = (m - c1) >>> 1.
REQ-024 Outputs are the low 16 bits of the results; no saturation.
REQ-025 oLeft and oRight hold their value when oValid=0.
REQ-026 A new iStart is accepted in the cycle after the return to S_IDLE, even while the last 2 pipeline stages drain; the drain completes unaffected.

Reset
REQ-027 On iReset, the following SHALL be cleared: state to S_IDLE, counters, latched size and assignment, pipeline valids, oValid, oBlockDone, oBusy, oError, oLeft, oRight.
REQ-028 Reset mid-block abandons the block: no further oValid, and buffer contents are don't-care.
REQ-029 The first block after reset behaves identically to any other block.

Structure
REQ-030 The shared package flac_pkg SHALL hold:
- the channel-assignment constants CH_MONO, CH_INDEP, CH_LEFT_SIDE, CH_SIDE_RIGHT, CH_MID_SIDE;
- MAX_BLOCK;
- the state encoding.
REQ-031 Sub-module channel_buffer: simple dual-port synchronous RAM, MAX_BLOCK x 17, with 1-cycle read latency.
REQ-032 The read address is issued in pipeline stage 1 and the combine is done in stage 2.

Verification
REQ-033 Assignment 1, N=4, ch0 = {1,2,3,4}, ch1 = {-1,-2,-3,-4}, back-to-back strobes -> 4 pairs (1,-1)..(4,-4), each 2 cycles after its strobe, oBlockDone on the 4th pair.
REQ-034 Assignment 10, N=2, M = {0,-3}, S = {1,-2} -> pairs (1,0) and (-4,-2).
REQ-035 Assignment 8, c0 = 32767, c1 = -1 -> R wraps to 16'h8000; assignment 9, S = 5, R = 7 -> (12,7).
REQ-036 iBlockSize = 0, or assignment 12 -> oError = 1, oBusy = 0, strobes ignored; the next valid iStart clears oError.
REQ-037 iReset after 2 of 4 ch1 samples -> no further oValid; a fresh block after reset completes correctly.
REQ-038 Mono, N = MAX_BLOCK with random samples; iStart asserted in the cycle after the last strobe -> a second block is accepted and all outputs match the model.
